// File: rtl/dual_port_mem_responder.sv
// Two-port (A = fetch, B = data) LC-3b memory responder over one shared word array.
// Optional protocol checker enabled by defining MEM_PROTOCOL_CHECK_EN.

module dual_port_mem_port #(
    parameter int       LATENCY = 2,
    parameter int       AW      = 10,
    parameter bit [7:0] PORT_ID = "A"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_read,
    input  logic          i_write,
    input  logic [1:0]    i_wmask,
    input  logic [15:0]   i_address,
    input  logic [15:0]   i_wdata,
    input  logic [15:0]   i_mem_word,
    output logic          o_resp,
    output logic [15:0]   o_rdata,
    output logic          o_commit,
    output logic [AW-1:0] o_idx,
    output logic [15:0]   o_wdata,
    output logic [1:0]    o_wmask,
    output logic          o_proto_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr, r_wdata, r_rdata;
    logic [1:0]  r_wmask;
    logic        r_op_wr;
    logic        w_req, w_accept, w_enter_resp, w_op_wr;
    logic [15:0] w_addr;
    logic        w_unused;

    assign w_req = i_read | i_write;

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: if (w_req) begin
                w_accept = 1'b1;
                if (LATENCY == 1) begin
                    w_next       = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: if (r_cnt == 4'd1) begin
                w_next       = S_RESP;
                w_enter_resp = 1'b1;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // With LATENCY=1 the commit happens on the accepting edge, so the live inputs are used
    assign w_addr   = (r_state == S_IDLE) ? i_address : r_addr;
    assign w_op_wr  = (r_state == S_IDLE) ? i_write   : r_op_wr;
    assign o_wdata  = (r_state == S_IDLE) ? i_wdata   : r_wdata;
    assign o_wmask  = (r_state == S_IDLE) ? i_wmask   : r_wmask;
    assign o_idx    = w_addr[AW:1];
    assign o_commit = w_enter_resp & w_op_wr;
    assign o_resp   = (r_state == S_RESP);
    assign o_rdata  = r_rdata;
    assign w_unused = ^{i_address >> (AW + 1), i_address[0], r_addr >> (AW + 1), r_addr[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_op_wr <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= CNT_LOAD;
                r_addr  <= i_address;
                r_wdata <= i_wdata;
                r_wmask <= i_wmask;
                r_op_wr <= i_write;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp)
                r_rdata <= i_mem_word;
        end
    end

`ifdef MEM_PROTOCOL_CHECK_EN
    logic r_err;
    logic w_viol;

    always_comb begin
        w_viol = i_read & i_write;
        if (r_state == S_WAIT) begin
            if (!w_req)
                w_viol = 1'b1;
            else if (i_address != r_addr || i_wdata != r_wdata ||
                     i_wmask != r_wmask || i_write != r_op_wr)
                w_viol = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_viol) begin
            r_err <= 1'b1;
            $error("mem responder port %s: protocol violation", PORT_ID);
        end
    end

    assign o_proto_err = r_err;
`else
    assign o_proto_err = 1'b0;
`endif
endmodule

module dual_port_mem_responder #(
    parameter int DEPTH     = 1024,
    parameter int LATENCY_A = 2,
    parameter int LATENCY_B = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_a,
    input  logic        write_a,
    input  logic [1:0]  wmask_a,
    input  logic [15:0] address_a,
    input  logic [15:0] wdata_a,
    output logic        resp_a,
    output logic [15:0] rdata_a,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b,
    output logic        proto_err
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic          w_commit_a, w_commit_b, w_err_a, w_err_b;
    logic [AW-1:0] w_idx_a, w_idx_b;
    logic [15:0]   w_wdata_a, w_wdata_b;
    logic [1:0]    w_wmask_a, w_wmask_b;

    dual_port_mem_port #(.LATENCY(LATENCY_A), .AW(AW), .PORT_ID("A")) u_port_a (
        .clk(clk), .rst(rst), .i_read(read_a), .i_write(write_a), .i_wmask(wmask_a),
        .i_address(address_a), .i_wdata(wdata_a), .i_mem_word(r_mem[w_idx_a]),
        .o_resp(resp_a), .o_rdata(rdata_a), .o_commit(w_commit_a), .o_idx(w_idx_a),
        .o_wdata(w_wdata_a), .o_wmask(w_wmask_a), .o_proto_err(w_err_a)
    );

    dual_port_mem_port #(.LATENCY(LATENCY_B), .AW(AW), .PORT_ID("B")) u_port_b (
        .clk(clk), .rst(rst), .i_read(read_b), .i_write(write_b), .i_wmask(wmask_b),
        .i_address(address_b), .i_wdata(wdata_b), .i_mem_word(r_mem[w_idx_b]),
        .o_resp(resp_b), .o_rdata(rdata_b), .o_commit(w_commit_b), .o_idx(w_idx_b),
        .o_wdata(w_wdata_b), .o_wmask(w_wmask_b), .o_proto_err(w_err_b)
    );

    // Port B is applied last so it wins on overlapping bytes of the same word
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_commit_a && w_wmask_a[0]) r_mem[w_idx_a][7:0]  <= w_wdata_a[7:0];
            if (w_commit_a && w_wmask_a[1]) r_mem[w_idx_a][15:8] <= w_wdata_a[15:8];
            if (w_commit_b && w_wmask_b[0]) r_mem[w_idx_b][7:0]  <= w_wdata_b[7:0];
            if (w_commit_b && w_wmask_b[1]) r_mem[w_idx_b][15:8] <= w_wdata_b[15:8];
        end
    end

    assign proto_err = w_err_a | w_err_b;
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Self-checking bench for dual_port_mem_responder: cycle-numbered transaction model
// checked every cycle, plus directed transactions with literal expectations.
`timescale 1ns/1ps

module tb_dual_port_mem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT [2] = '{2, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_a = 0, write_a = 0, read_b = 0, write_b = 0;
    logic [1:0]  wmask_a = 0, wmask_b = 0;
    logic [15:0] address_a = 0, wdata_a = 0, address_b = 0, wdata_b = 0;
    logic        resp_a, resp_b, proto_err;
    logic [15:0] rdata_a, rdata_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    dual_port_mem_responder #(.DEPTH(DEPTH), .LATENCY_A(2), .LATENCY_B(3)) dut (
        .clk(clk), .rst(rst),
        .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a),
        .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_busy [2];
    int          m_acc [2], m_due [2];
    logic [15:0] m_addr [2], m_wd [2], m_exp_rd [2];
    logic [1:0]  m_wm [2];
    bit          m_wr [2], m_rd_known [2];
    bit          m_perr = 0;

    always @(negedge clk) begin
        logic        req [2], rd [2], wr [2], resp [2], ent [2];
        logic [15:0] ad [2], wd [2], rdat [2];
        logic [1:0]  wm [2];
        int          idx;
        rd[0] = read_a;  wr[0] = write_a; ad[0] = address_a; wd[0] = wdata_a; wm[0] = wmask_a;
        rd[1] = read_b;  wr[1] = write_b; ad[1] = address_b; wd[1] = wdata_b; wm[1] = wmask_b;
        resp[0] = resp_a; resp[1] = resp_b; rdat[0] = rdata_a; rdat[1] = rdata_b;
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                m_busy[p] = 0; m_exp_rd[p] = 16'h0; m_rd_known[p] = 1;
                chk(p == 0 ? "rst_resp_a" : "rst_resp_b", {31'b0, resp[p]}, 32'd0);
                chk(p == 0 ? "rst_rdata_a" : "rst_rdata_b", {16'b0, rdat[p]}, 32'd0);
            end
            m_perr = 0;
            chk("rst_proto_err", {31'b0, proto_err}, 32'd0);
        end else begin
            for (int p = 0; p < 2; p++) begin
                req[p] = rd[p] | wr[p];
                chk(p == 0 ? "model_resp_a" : "model_resp_b", {31'b0, resp[p]},
                    {31'b0, (m_busy[p] && m_due[p] == cyc)});
                if (m_rd_known[p])
                    chk(p == 0 ? "model_rdata_a" : "model_rdata_b", {16'b0, rdat[p]}, {16'b0, m_exp_rd[p]});
            end
            chk("model_proto_err", {31'b0, proto_err}, {31'b0, m_perr});
`ifdef MEM_PROTOCOL_CHECK_EN
            for (int p = 0; p < 2; p++) begin
                if (rd[p] && wr[p]) m_perr = 1;
                if (m_busy[p] && cyc > m_acc[p] && cyc < m_due[p]) begin
                    if (!req[p]) m_perr = 1;
                    else if (ad[p] != m_addr[p] || wd[p] != m_wd[p] || wm[p] != m_wm[p] || wr[p] != m_wr[p])
                        m_perr = 1;
                end
            end
`endif
            for (int p = 0; p < 2; p++) begin
                if (m_busy[p] && m_due[p] == cyc) begin
                    m_busy[p] = 0;
                end else if (!m_busy[p] && req[p]) begin
                    m_busy[p] = 1; m_acc[p] = cyc; m_due[p] = cyc + LAT[p];
                    m_addr[p] = ad[p]; m_wd[p] = wd[p]; m_wm[p] = wm[p]; m_wr[p] = wr[p];
                end
                ent[p] = m_busy[p] && m_due[p] == cyc + 1;
            end
            // all reads of an edge see the array before any of that edge's writes
            for (int p = 0; p < 2; p++) if (ent[p]) begin
                idx = (m_addr[p] / 2) % DEPTH;
                m_exp_rd[p] = m_mem[idx]; m_rd_known[p] = m_known[idx];
            end
            for (int p = 0; p < 2; p++) if (ent[p] && m_wr[p]) begin
                idx = (m_addr[p] / 2) % DEPTH;
                if (m_wm[p][0]) m_mem[idx][7:0]  = m_wd[p][7:0];
                if (m_wm[p][1]) m_mem[idx][15:8] = m_wd[p][15:8];
                if (m_wm[p] == 2'b11) m_known[idx] = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit pb, input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] data, input logic [1:0] mask);
        if (!pb) begin read_a = rd; write_a = wr; address_a = addr; wdata_a = data; wmask_a = mask; end
        else     begin read_b = rd; write_b = wr; address_b = addr; wdata_b = data; wmask_b = mask; end
    endtask

    task automatic txn(input bit pb, input bit wr, input logic [15:0] addr, input logic [15:0] data,
                       input logic [1:0] mask, output logic [15:0] rd, output int lat);
        int start;
        bit got;
        @(posedge clk); #1;
        drive(pb, !wr, wr, addr, data, mask);
        start = cyc; got = 0; rd = '0; lat = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (pb ? resp_b : resp_a) begin
                got = 1; lat = cyc - start; rd = pb ? rdata_b : rdata_a;
            end
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL txn_timeout: port %0d got no resp, required one within 40 cycles", pb);
        end
        @(posedge clk); #1;
        drive(pb, 0, 0, addr, 16'h0, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd, rd2;
        int lat, lat2, cnt;

        repeat (3) @(posedge clk);
        #1 rst = 0;

        txn(0, 1, 16'h0010, 16'h1234, 2'b11, rd, lat);
        txn(1, 1, 16'h0020, 16'h7777, 2'b11, rd, lat);

        // reset mid-WAIT on port B drops the pending write
        @(posedge clk); #1;
        drive(1, 0, 1, 16'h0020, 16'h0000, 2'b11);
        @(posedge clk); #1;
        rst = 1; drive(1, 0, 0, 16'h0020, 16'h0, 2'b00);
        @(negedge clk);
        chk("t1_resp_b_in_rst", {31'b0, resp_b}, 32'd0);
        chk("t1_rdata_b_in_rst", {16'b0, rdata_b}, 32'd0);
        @(posedge clk); #1 rst = 0;
        cnt = 0;
        repeat (4) begin @(negedge clk); if (resp_b) cnt++; end
        chk("t1_no_resp_after_rst", cnt, 0);
        txn(0, 0, 16'h0020, 16'h0, 2'b00, rd, lat);
        chk("t1_word_unchanged", {16'b0, rd}, 32'h7777);

        // write on B then fetch on A, with latency
        txn(1, 1, 16'h3000, 16'hBEEF, 2'b11, rd, lat);
        chk("t2_lat_b", lat, 3);
        txn(0, 0, 16'h3000, 16'h0, 2'b00, rd, lat);
        chk("t2_rdata_a", {16'b0, rd}, 32'hBEEF);
        chk("t2_lat_a", lat, 2);

        // byte masks
        txn(1, 1, 16'h0010, 16'hAB00, 2'b10, rd, lat);
        chk("t3_write_returns_old", {16'b0, rd}, 32'h1234);
        txn(1, 0, 16'h0010, 16'h0, 2'b00, rd, lat);
        chk("t3_mask10", {16'b0, rd}, 32'hAB34);
        txn(1, 1, 16'h0010, 16'hFFFF, 2'b00, rd, lat);
        txn(0, 0, 16'h0010, 16'h0, 2'b00, rd, lat);
        chk("t3_mask00", {16'b0, rd}, 32'hAB34);

        // same-edge commits from both ports (B issued one cycle earlier)
        txn(0, 1, 16'h0040, 16'h0000, 2'b11, rd, lat);
        fork
            txn(1, 1, 16'h0040, 16'h2222, 2'b01, rd, lat);
            begin @(posedge clk); txn(0, 1, 16'h0040, 16'h1111, 2'b11, rd2, lat2); end
        join
        txn(0, 0, 16'h0040, 16'h0, 2'b00, rd, lat);
        chk("t4_b_wins_low_byte", {16'b0, rd}, 32'h1122);

        // same-edge A write / B read: B sees the old word
        fork
            txn(1, 0, 16'h0040, 16'h0, 2'b00, rd, lat);
            begin @(posedge clk); txn(0, 1, 16'h0040, 16'h9999, 2'b11, rd2, lat2); end
        join
        chk("xport_old_word", {16'b0, rd}, 32'h1122);
        txn(1, 0, 16'h0040, 16'h0, 2'b00, rd, lat);
        chk("xport_later_new", {16'b0, rd}, 32'h9999);

        // address aliasing
        txn(0, 1, 16'h0800, 16'h5A5A, 2'b11, rd, lat);
        txn(1, 0, 16'h0000, 16'h0, 2'b00, rd, lat);
        chk("t5_alias_0000", {16'b0, rd}, 32'h5A5A);
        txn(0, 0, 16'h0801, 16'h0, 2'b00, rd, lat);
        chk("t5_alias_0801", {16'b0, rd}, 32'h5A5A);

        // held request: one transaction per LATENCY+1 cycles
        @(posedge clk); #1;
        drive(0, 1, 0, 16'h3000, 16'h0, 2'b00);
        cnt = 0;
        repeat (6) begin @(negedge clk); if (resp_a) cnt++; end
        @(posedge clk); #1;
        drive(0, 0, 0, 16'h0, 16'h0, 2'b00);
        chk("b2b_resp_count", cnt, 2);
        repeat (3) @(posedge clk);
        chk("proto_err_clean", {31'b0, proto_err}, 32'd0);

`ifdef MEM_PROTOCOL_CHECK_EN
        @(posedge clk); #1;
        drive(0, 1, 0, 16'h0010, 16'h0, 2'b00);
        @(posedge clk); #1;
        address_a = 16'h3000;
        cnt = 0;
        for (int k = 0; k < 10 && cnt == 0; k++) begin
            @(negedge clk);
            if (resp_a) begin cnt = 1; chk("t6_rdata_latched_addr", {16'b0, rdata_a}, 32'hAB34); end
        end
        chk("t6_resp_seen", cnt, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 16'h0, 16'h0, 2'b00);
        repeat (3) @(posedge clk);
        #1 chk("t6_proto_err_held", {31'b0, proto_err}, 32'd1);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("t6_proto_err_cleared", {31'b0, proto_err}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
